// File: rtl/lcd_serial_rx.sv
// ---------------------------------------------------------------------------
// lcd_serial_rx
//
// Receiver for an LCD-style three-wire serial link (csx / scl / sda). The
// serial inputs are asynchronous to clk. Each one passes through its own
// synchronizer chain and is then edge-detected in the clk domain. Bytes
// arrive MSB first, one bit per scl rising edge, while csx is low. Several
// bytes may follow each other inside one csx-low frame. Each completed byte
// goes into a one-entry holding register, read with a valid/ready handshake.
//
// Ports
//   clk          single clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   sync_reset   synchronous clear (synchronizer chains keep running)
//   csx          serial chip select, active low (asynchronous)
//   scl          serial clock (asynchronous)
//   sda          serial data, MSB first (asynchronous)
//   data_out     received byte from the holding register
//   data_valid   holding register full
//   data_ready   consumer accepts data_out while data_valid is high
//   overrun      one-clk pulse when a completed byte is dropped
//   frame_error  one-clk pulse when csx deasserts mid-byte
//   busy         high while synchronized csx is low
// ---------------------------------------------------------------------------
module lcd_serial_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync_reset,
    input  logic       csx,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Synchronizer chains plus the previous-sample flops used for edge
    // detection. sync_reset leaves these alone. If it reloaded the previous
    // csx sample while csx is still low, a false falling edge would be seen
    // and reception would restart in the middle of a frame.
    logic [SYNC_STAGES-1:0] csx_sync_q, csx_sync_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   csx_prev_q, csx_prev_d;
    logic                   scl_prev_q, scl_prev_d;

    logic csx_s;
    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic csx_fall_s;
    logic csx_rise_s;

    // Receiver state
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_error_q, frame_error_d;

    // Next value of each synchronizer chain: shift the raw input in at bit 0
    always_comb begin
        csx_sync_d = {csx_sync_q[SYNC_STAGES-2:0], csx};
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        csx_prev_d = csx_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-history registers (asynchronous reset only)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csx_sync_q <= {SYNC_STAGES{1'b1}};
            scl_sync_q <= {SYNC_STAGES{1'b0}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            csx_prev_q <= 1'b1;
            scl_prev_q <= 1'b0;
        end else begin
            csx_sync_q <= csx_sync_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            csx_prev_q <= csx_prev_d;
            scl_prev_q <= scl_prev_d;
        end
    end

    assign csx_s      = csx_sync_q[SYNC_STAGES-1];
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign csx_fall_s = ~csx_s & csx_prev_q;
    assign csx_rise_s = csx_s & ~csx_prev_q;

    // Next-state and output logic for the receive FSM and the holding register
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        overrun_d     = 1'b0;
        frame_error_d = 1'b0;

        // Consumer handshake. A commit further down may set valid again in
        // the same clk.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (csx_fall_s) begin
                    bit_cnt_d = 3'd0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_SHIFT: begin
                // An scl edge that completes the byte wins over a csx rise
                // detected in the same clk.
                if (scl_rise_s && (bit_cnt_q == 3'd7)) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = 3'd0;
                    state_d   = S_COMMIT;
                end else if (csx_rise_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        frame_error_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b0;
                    end
                    bit_cnt_d = 3'd0;
                    state_d   = S_IDLE;
                end else if (scl_rise_s) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    state_d   = S_SHIFT;
                end
            end

            S_COMMIT: begin
                // The byte is accepted if the holding register is empty or is
                // being emptied in this same clk. Otherwise the new byte is
                // dropped.
                if (!data_valid_q || data_ready) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                end else begin
                    overrun_d    = 1'b1;
                end
                // A csx rise during the commit only decides where we go next.
                if (csx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end

            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase

        // Synchronous clear overrides everything, including pulses.
        if (sync_reset) begin
            state_d       = S_IDLE;
            bit_cnt_d     = 3'd0;
            shift_d       = 8'd0;
            data_out_d    = 8'd0;
            data_valid_d  = 1'b0;
            overrun_d     = 1'b0;
            frame_error_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Receive FSM, shift register and holding register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            data_out_q    <= 8'd0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;
    // Taken straight from the last synchronizer flop.
    assign busy        = ~csx_s;

endmodule

// File: doc/lcd_serial_rx.md
LCD_SERIAL_RX -- requirements
Module: lcd_serial_rx

Interface
REQ-001 The module SHALL have one parameter: SYNC_STAGES, default 2, the number of flops in each input synchronizer (minimum 2).
REQ-002 The module SHALL have the port: clk  input  1  the single clock; all logic rises on its posedge.
REQ-003 The module SHALL have the port: reset_n  input  1  asynchronous active-low reset.
REQ-004 The module SHALL have the port: sync_reset  input  1  synchronous clear, active high.
REQ-005 The module SHALL have the port: csx  input  1  serial chip select, active low, asynchronous to clk.
REQ-006 The module SHALL have the port: scl  input  1  serial clock, asynchronous to clk.
REQ-007 The module SHALL have the port: sda  input  1  serial data, MSB first, asynchronous to clk.
REQ-008 The module SHALL have the port: data_out  output  8  received byte from the holding register.
REQ-009 The module SHALL have the port: data_valid  output  1  holding register full.
REQ-010 The module SHALL have the port: data_ready  input  1  consumer accepts data_out when data_valid is high.
REQ-011 The module SHALL have the port: overrun  output  1  one-clk pulse when a completed byte is dropped.
REQ-012 The module SHALL have the port: frame_error  output  1  one-clk pulse when csx deasserts mid-byte.
REQ-013 The module SHALL have the port: busy  output  1  high while synchronized csx is low.

Function
REQ-014 Each of csx, scl and sda SHALL pass through a SYNC_STAGES flop chain; chain reset values SHALL be csx=1, scl=0, sda=1.
REQ-015 An scl rising edge SHALL be detected as sync scl=1 with the previous sync scl=0; csx falling and rising edges SHALL be detected the same way.
REQ-016 The FSM SHALL have the states S_IDLE, S_SHIFT and S_COMMIT.
REQ-017 In S_IDLE, a sync csx falling edge SHALL clear the 3-bit bit counter and move the FSM to S_SHIFT; scl edges SHALL be ignored.
REQ-018 In S_SHIFT, each scl rising edge SHALL shift sync sda into the LSB of the 8-bit shift register and increment the bit counter.
REQ-019 The edge that completes the 8th bit SHALL move the FSM to S_COMMIT, with the bit counter wrapping to 0.
REQ-020 In S_COMMIT, for one clk, the FSM SHALL commit the byte; it SHALL then return to S_SHIFT if sync csx is low, else to S_IDLE.
REQ-021 Commit SHALL load the byte into data_out and set data_valid when data_valid is 0 or when data_valid & data_ready is true in the same clk.
REQ-022 Otherwise, commit SHALL keep data_out unchanged, discard the new byte and pulse overrun.
REQ-023 Commit latency: data_valid SHALL go high 2 clk after the clk in which the 8th scl rising edge is detected.
REQ-024 data_valid SHALL clear on data_valid & data_ready unless a commit in the same clk reloads it.
REQ-025 data_out SHALL be stable while data_valid is high and not accepted.
REQ-026 Multiple bytes SHALL be received back-to-back within one csx-low frame without csx toggling.
REQ-027 A sync csx rising edge in S_SHIFT with bit counter 1..7 SHALL pulse frame_error, discard the partial byte and return the FSM to S_IDLE.
REQ-028 A sync csx rising edge with bit counter 0 SHALL return the FSM to S_IDLE silently.
REQ-029 If an 8th-bit scl edge and a csx rising edge fall in the same clk, the scl edge SHALL take precedence: the byte commits, with no frame_error.
REQ-030 A csx rising edge that occurs while the FSM is in S_COMMIT SHALL NOT abort the commit.
REQ-031 busy SHALL equal NOT sync csx.

Reset
REQ-032 On reset_n low: FSM=S_IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, overrun=0, frame_error=0, synchronizers at their REQ-014 values, busy=0.
REQ-033 On sync_reset high, all state except the synchronizer chains SHALL take the REQ-032 values at the next clk edge, including mid-byte, with no frame_error or overrun pulse.
REQ-034 After either reset, reception SHALL begin only at the next sync csx falling edge.

Verification
REQ-035 With data_ready=1, one frame sending 0xA5 -> data_out=0xA5; data_valid high 1 clk, 2 clk after the 8th scl rise; no error pulses.
REQ-036 With data_ready=0, a frame sending 0x3C, 0xC3 -> data_out=0x3C held, one overrun pulse; raising data_ready then yields 0x3C once.
REQ-037 With csx high after 5 scl edges -> one frame_error pulse, data_valid stays 0; the next frame sending 0x81 -> 0x81 received.
REQ-038 scl toggling while csx is high -> no shift, no data_valid, no error.
REQ-039 sync_reset after 4 bits, then a new frame sending 0x7E -> 0x7E received, no frame_error.
REQ-040 The 8th scl rise and csx rise aligned to the same clk -> byte committed, frame_error=0.
